// File: rtl/input_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : input_event_scheduler
// Description : Buffers keyboard and mouse events from the keyboard serial
//               block in two small FIFOs, hands them downstream one at a time
//               through a valid/ready register with round-robin fairness, and
//               paces host LED updates so at most one LED pulse is sent per
//               LED_HOLDOFF clock cycles.
//
// Ports
//   clk            in   1   monitor clock, rising edge
//   rst_n          in   1   synchronous active-low reset
//   kb_data_ready  in   1   event strobe (rising edge = one event)
//   kb_is_mouse    in   1   event type: 1 = mouse, 0 = keyboard
//   kb_data        in  16   event payload
//   out_valid      out  1   scheduled event available
//   out_ready      in   1   downstream accepts the event
//   out_data       out 16   scheduled event payload
//   out_is_mouse   out  1   scheduled event type
//   led_req_valid  in   1   host LED update request strobe
//   led_req        in   2   requested LED state
//   led_data_valid out  1   one-cycle LED update pulse
//   led_data       out  2   LED state accompanying led_data_valid
//   drop_count     out  8   saturating count of events dropped on full FIFO
//
// Revision    : 1.0 - initial release
// ============================================================================
module input_event_scheduler #(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [13:0] LED_HOLDOFF = 14'd10600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        kb_data_ready,
    input  logic        kb_is_mouse,
    input  logic [15:0] kb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_is_mouse,
    input  logic        led_req_valid,
    input  logic [1:0]  led_req,
    output logic        led_data_valid,
    output logic [1:0]  led_data,
    output logic [7:0]  drop_count
);

    localparam int c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_ENTRY_W = 17;  // {type, data}
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);

    // FIFO index 0 is the keyboard FIFO, index 1 the mouse FIFO.
    localparam int c_NUM_FIFO = 2;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } sched_state_t;

    typedef enum logic [1:0] {
        L_IDLE    = 2'd0,
        L_EMIT    = 2'd1,
        L_HOLDOFF = 2'd2
    } led_state_t;

    // ------------------------------------------------------------------------
    // Event strobe edge detection
    // ------------------------------------------------------------------------
    logic                  r_kb_ready_d;
    logic                  w_push;
    logic [c_ENTRY_W-1:0]  w_push_entry;
    logic [c_NUM_FIFO-1:0] w_push_sel;

    // The delayed copy resets to 1 so that a strobe already high when reset
    // is released is not mistaken for a new event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_kb_ready_d <= 1'b1;
        end else begin
            r_kb_ready_d <= kb_data_ready;
        end
    end

    assign w_push       = kb_data_ready && !r_kb_ready_d;
    assign w_push_entry = {kb_is_mouse, kb_data};
    assign w_push_sel   = {w_push && kb_is_mouse, w_push && !kb_is_mouse};

    // ------------------------------------------------------------------------
    // Event FIFOs
    // ------------------------------------------------------------------------
    logic [c_NUM_FIFO-1:0]                w_fifo_empty;
    logic [c_NUM_FIFO-1:0]                w_fifo_full;
    logic [c_NUM_FIFO-1:0][c_ENTRY_W-1:0] w_fifo_head;
    logic [c_NUM_FIFO-1:0]                w_pop_sel;

    for (genvar g = 0; g < c_NUM_FIFO; g++) begin : g_fifo
        logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
        logic [c_PTR_W-1:0]   r_wr_ptr;
        logic [c_PTR_W-1:0]   r_rd_ptr;
        logic [c_CNT_W-1:0]   r_count;
        logic                 w_wr_en;

        // A full FIFO still accepts a push when it is popped in the same
        // cycle; the write lands in the slot being read out, which is safe
        // because the read uses the pre-edge contents.
        assign w_wr_en = w_push_sel[g] && (!w_fifo_full[g] || w_pop_sel[g]);

        assign w_fifo_empty[g] = (r_count == '0);
        assign w_fifo_full[g]  = (r_count == c_FULL);
        assign w_fifo_head[g]  = r_mem[r_rd_ptr];

        // Storage needs no reset: the count guards every read.
        always_ff @(posedge clk) begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= w_push_entry;
            end
        end

        // Pointers wrap naturally because FIFO_DEPTH is a power of two.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_wr_en) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop_sel[g]) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_wr_en, w_pop_sel[g]})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Drop counter
    // ------------------------------------------------------------------------
    logic       w_drop;
    logic [7:0] r_drop_count;

    assign w_drop = |(w_push_sel & w_fifo_full & ~w_pop_sel);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_count <= 8'd0;
        end else if (w_drop && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign drop_count = r_drop_count;

    // ------------------------------------------------------------------------
    // Scheduler: arbitration and output register
    // ------------------------------------------------------------------------
    sched_state_t         r_sched_state;
    logic                 r_out_valid;
    logic [15:0]          r_out_data;
    logic                 r_out_is_mouse;
    logic                 r_last_mouse;
    logic                 w_can_issue;
    logic [c_ENTRY_W-1:0] w_pop_entry;

    // The output register can take a new entry when it is empty or when its
    // current entry is being accepted this cycle.
    assign w_can_issue = (r_sched_state == S_IDLE) || (r_out_valid && out_ready);

    // Round-robin only matters when both FIFOs have data; otherwise the
    // single non-empty FIFO is served.
    always_comb begin
        w_pop_sel = '0;
        if (w_can_issue) begin
            if (!w_fifo_empty[0] && !w_fifo_empty[1]) begin
                if (r_last_mouse) begin
                    w_pop_sel[0] = 1'b1;
                end else begin
                    w_pop_sel[1] = 1'b1;
                end
            end else if (!w_fifo_empty[0]) begin
                w_pop_sel[0] = 1'b1;
            end else if (!w_fifo_empty[1]) begin
                w_pop_sel[1] = 1'b1;
            end
        end
    end

    assign w_pop_entry = w_pop_sel[1] ? w_fifo_head[1] : w_fifo_head[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sched_state  <= S_IDLE;
            r_out_valid    <= 1'b0;
            r_out_data     <= 16'h0000;
            r_out_is_mouse <= 1'b0;
            r_last_mouse   <= 1'b1;
        end else begin
            case (r_sched_state)
                S_IDLE: begin
                    if (|w_pop_sel) begin
                        r_out_valid    <= 1'b1;
                        r_out_data     <= w_pop_entry[15:0];
                        r_out_is_mouse <= w_pop_entry[16];
                        r_last_mouse   <= w_pop_sel[1];
                        r_sched_state  <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        if (|w_pop_sel) begin
                            r_out_data     <= w_pop_entry[15:0];
                            r_out_is_mouse <= w_pop_entry[16];
                            r_last_mouse   <= w_pop_sel[1];
                        end else begin
                            r_out_valid    <= 1'b0;
                            r_sched_state  <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_out_valid   <= 1'b0;
                    r_sched_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_is_mouse = r_out_is_mouse;

    // ------------------------------------------------------------------------
    // LED update pacing
    // ------------------------------------------------------------------------
    led_state_t  r_led_state;
    logic        r_led_pending;
    logic [1:0]  r_led_pend_val;
    logic [13:0] r_led_cnt;
    logic        r_led_valid;
    logic [1:0]  r_led_data;

    // The pulse register is set on the same edge that enters L_EMIT, so the
    // pulse is visible exactly while the FSM sits in L_EMIT.
    //
    // The holdoff is left on the decrement that reaches zero, and a request
    // that arrived meanwhile goes straight to L_EMIT. Together with the one
    // L_EMIT cycle this spaces consecutive pulses exactly LED_HOLDOFF cycles
    // apart. LED_HOLDOFF is expected to be at least 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_led_state    <= L_IDLE;
            r_led_pending  <= 1'b0;
            r_led_pend_val <= 2'b00;
            r_led_cnt      <= 14'd0;
            r_led_valid    <= 1'b0;
            r_led_data     <= 2'b00;
        end else begin
            r_led_valid <= 1'b0;

            // Latest request wins, in every state.
            if (led_req_valid) begin
                r_led_pend_val <= led_req;
                r_led_pending  <= 1'b1;
            end

            case (r_led_state)
                L_IDLE: begin
                    if (r_led_pending) begin
                        r_led_valid <= 1'b1;
                        r_led_data  <= r_led_pend_val;
                        r_led_state <= L_EMIT;
                    end
                end
                L_EMIT: begin
                    // A request arriving during the pulse stays pending.
                    if (!led_req_valid) begin
                        r_led_pending <= 1'b0;
                    end
                    r_led_cnt   <= LED_HOLDOFF - 14'd1;
                    r_led_state <= L_HOLDOFF;
                end
                L_HOLDOFF: begin
                    if (r_led_cnt <= 14'd1) begin
                        r_led_cnt <= 14'd0;
                        if (r_led_pending) begin
                            r_led_valid <= 1'b1;
                            r_led_data  <= r_led_pend_val;
                            r_led_state <= L_EMIT;
                        end else begin
                            r_led_state <= L_IDLE;
                        end
                    end else begin
                        r_led_cnt <= r_led_cnt - 14'd1;
                    end
                end
                default: begin
                    r_led_state <= L_IDLE;
                end
            endcase
        end
    end

    assign led_data_valid = r_led_valid;
    assign led_data       = r_led_data;

endmodule
`default_nettype wire

// File: tb/tb_input_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_event_scheduler
// Description : Directed self-checking bench for input_event_scheduler
//               (FIFO_DEPTH = 4, LED_HOLDOFF = 50).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_event_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        kb_data_ready;
    logic        kb_is_mouse;
    logic [15:0] kb_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_is_mouse;
    logic        led_req_valid;
    logic [1:0]  led_req;
    logic        led_data_valid;
    logic [1:0]  led_data;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_fails  = 0;

    logic [15:0] kb_q [$];
    logic [15:0] ms_q [$];
    logic        bp_done;
    int          bp_rcvd;

    input_event_scheduler #(
        .FIFO_DEPTH  (4),
        .LED_HOLDOFF (14'd50)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .kb_data_ready  (kb_data_ready),
        .kb_is_mouse    (kb_is_mouse),
        .kb_data        (kb_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_is_mouse   (out_is_mouse),
        .led_req_valid  (led_req_valid),
        .led_req        (led_req),
        .led_data_valid (led_data_valid),
        .led_data       (led_data),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One event: strobe high for one cycle, then low for one cycle.
    task automatic push(input logic m, input logic [15:0] d);
        kb_is_mouse   = m;
        kb_data       = d;
        kb_data_ready = 1'b1;
        tick();
        kb_data_ready = 1'b0;
        tick();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] fair_data [6];
        logic        fair_mouse [6];
        int          cnt;

        rst_n         = 1'b0;
        kb_data_ready = 1'b1;
        kb_is_mouse   = 1'b0;
        kb_data       = 16'h0000;
        out_ready     = 1'b0;
        led_req_valid = 1'b0;
        led_req       = 2'b00;
        bp_done       = 1'b0;
        bp_rcvd       = 0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_is_mouse", out_is_mouse, 0);
        check_eq("rst_led_valid", led_data_valid, 0);
        check_eq("rst_led_data", led_data, 0);
        check_eq("rst_drop_count", drop_count, 0);

        // Strobe held high across reset release must not push.
        rst_n = 1'b1;
        cnt   = 0;
        repeat (5) begin
            tick();
            if (out_valid) cnt++;
        end
        check_eq("rst_level_no_push", cnt, 0);
        kb_data_ready = 1'b0;
        tick();

        // ---------------- single event, latency ----------------
        out_ready     = 1'b1;
        kb_is_mouse   = 1'b0;
        kb_data       = 16'h2A31;
        kb_data_ready = 1'b1;          // push cycle N, level held afterwards
        tick();                        // N+1
        check_eq("single_valid_n1", out_valid, 0);
        tick();                        // N+2
        check_eq("single_valid_n2", out_valid, 1);
        check_eq("single_data", out_data, 16'h2A31);
        check_eq("single_is_mouse", out_is_mouse, 0);
        tick();                        // N+3
        check_eq("single_valid_n3", out_valid, 0);
        tick();                        // N+4: held level gave no second push
        check_eq("single_valid_n4", out_valid, 0);
        kb_data_ready = 1'b0;
        tick();

        // ---------------- fairness ----------------
        out_ready = 1'b0;
        fair_data  = '{16'h1000, 16'h2000, 16'h1001, 16'h2001, 16'h1002, 16'h2002};
        fair_mouse = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        push(1'b0, 16'h1000);
        push(1'b0, 16'h1001);
        push(1'b0, 16'h1002);
        push(1'b1, 16'h2000);
        push(1'b1, 16'h2001);
        push(1'b1, 16'h2002);
        repeat (2) tick();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("fair_valid_%0d", i), out_valid, 1);
            check_eq($sformatf("fair_data_%0d", i), out_data, fair_data[i]);
            check_eq($sformatf("fair_type_%0d", i), out_is_mouse, fair_mouse[i]);
            tick();
        end
        check_eq("fair_drained", out_valid, 0);
        out_ready = 1'b0;
        tick();

        // ---------------- overflow ----------------
        for (int i = 0; i < 6; i++) push(1'b0, 16'h3000 + 16'(i));
        check_eq("ovf_held_valid", out_valid, 1);
        check_eq("ovf_held_data", out_data, 16'h3000);
        check_eq("ovf_drop_one", drop_count, 1);
        for (int i = 0; i < 300; i++) push(1'b0, 16'h4000 + 16'(i));
        check_eq("ovf_drop_sat", drop_count, 255);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("ovf_data_%0d", i), out_data, 16'h3000 + 16'(i));
            tick();
        end
        check_eq("ovf_drained", out_valid, 0);
        out_ready = 1'b0;
        tick();

        // ---------------- reset mid-stream ----------------
        for (int i = 0; i < 4; i++) push(1'b1, 16'h5000 + 16'(i));
        check_eq("mrst_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        tick();
        check_eq("mrst_valid", out_valid, 0);
        check_eq("mrst_drop_count", drop_count, 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cnt       = 0;
        repeat (10) begin
            tick();
            if (out_valid) cnt++;
        end
        check_eq("mrst_no_stale", cnt, 0);
        out_ready = 1'b0;

        // ---------------- backpressure ----------------
        fork
            begin : bp_drive
                logic [15:0] d;
                logic        m;
                for (int i = 0; i < 100; i++) begin
                    m = 1'($urandom_range(0, 1));
                    d = 16'($urandom);
                    if (m) ms_q.push_back(d);
                    else   kb_q.push_back(d);
                    kb_is_mouse   = m;
                    kb_data       = d;
                    kb_data_ready = 1'b1;
                    tick();
                    kb_data_ready = 1'b0;
                    repeat (3) tick();
                end
            end
            begin : bp_ready
                int zeros;
                zeros = 0;
                while (!bp_done) begin
                    if (zeros >= 2) begin
                        out_ready = 1'b1;
                    end else begin
                        out_ready = 1'($urandom_range(0, 1));
                    end
                    zeros = out_ready ? 0 : zeros + 1;
                    tick();
                end
            end
            begin : bp_monitor
                logic        prev_stall;
                logic [15:0] prev_data;
                logic [15:0] exp_d;
                int          cyc;
                prev_stall = 1'b0;
                prev_data  = 16'h0000;
                cyc        = 0;
                while (!bp_done) begin
                    @(negedge clk);
                    cyc++;
                    if (prev_stall) begin
                        check_eq("bp_stable_valid", out_valid, 1);
                        check_eq("bp_stable_data", out_data, prev_data);
                    end
                    if (out_valid && out_ready) begin
                        if (out_is_mouse) begin
                            check_eq("bp_ms_avail", {31'b0, ms_q.size() != 0}, 1);
                            if (ms_q.size() != 0) begin
                                exp_d = ms_q.pop_front();
                                check_eq("bp_ms_data", out_data, exp_d);
                            end
                        end else begin
                            check_eq("bp_kb_avail", {31'b0, kb_q.size() != 0}, 1);
                            if (kb_q.size() != 0) begin
                                exp_d = kb_q.pop_front();
                                check_eq("bp_kb_data", out_data, exp_d);
                            end
                        end
                        bp_rcvd++;
                    end
                    prev_stall = out_valid && !out_ready;
                    prev_data  = out_data;
                    if (bp_rcvd >= 100) begin
                        bp_done = 1'b1;
                    end else if (cyc > 3000) begin
                        check_eq("bp_timeout_rcvd", bp_rcvd, 100);
                        bp_done = 1'b1;
                    end
                end
            end
        join
        out_ready = 1'b0;
        repeat (3) tick();
        check_eq("bp_rcvd", bp_rcvd, 100);
        check_eq("bp_kb_left", kb_q.size(), 0);
        check_eq("bp_ms_left", ms_q.size(), 0);
        check_eq("bp_drop_count", drop_count, 0);
        check_eq("bp_idle", out_valid, 0);

        // ---------------- LED pacing ----------------
        led_req_valid = 1'b1;          // request cycle R
        led_req       = 2'b01;
        tick();                        // R+1
        led_req_valid = 1'b0;
        check_eq("led_r1_valid", led_data_valid, 0);
        tick();                        // R+2 = P
        check_eq("led_first_valid", led_data_valid, 1);
        check_eq("led_first_data", led_data, 2'b01);
        cnt = 0;
        for (int k = 1; k <= 120; k++) begin
            if (k == 8) begin          // R+10
                led_req_valid = 1'b1;
                led_req       = 2'b11;
            end else begin
                led_req_valid = 1'b0;
            end
            tick();                    // cycle P+k
            if (k == 49) begin
                check_eq("led_hold_valid", led_data_valid, 0);
                check_eq("led_hold_data", led_data, 2'b01);
            end else if (k == 50) begin
                check_eq("led_second_valid", led_data_valid, 1);
                check_eq("led_second_data", led_data, 2'b11);
            end else if (led_data_valid) begin
                cnt++;
            end
        end
        check_eq("led_extra_pulses", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/input_event_scheduler.md
INPUT_EVENT_SCHEDULER -- requirements
Module: input_event_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: entries per event FIFO; a power of two, at least 2.
REQ-002 Parameter LED_HOLDOFF, default 14'd10600: minimum clk cycles between LED pulses (one 40-tick keyboard polling frame).
REQ-003 clk  input  1  monitor clock; all logic updates on its rising edge.
REQ-004 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 kb_data_ready  input  1  event strobe from the keyboard serial block.
REQ-006 kb_is_mouse  input  1  event type qualifier: 1 = mouse, 0 = keyboard.
REQ-007 kb_data  input  16  event payload.
REQ-008 out_valid  output  1  scheduled event available.
REQ-009 out_ready  input  1  downstream accepts the event.
REQ-010 out_data  output  16  scheduled event payload.
REQ-011 out_is_mouse  output  1  type of the scheduled event.
REQ-012 led_req_valid  input  1  host LED update request strobe.
REQ-013 led_req  input  2  requested LED state.
REQ-014 led_data_valid  output  1  one-cycle LED update pulse to the keyboard serial block.
REQ-015 led_data  output  2  LED state that accompanies led_data_valid.
REQ-016 drop_count  output  8  saturating count of events dropped because a FIFO was full.

Function
REQ-017 Push condition: a rising edge of kb_data_ready (registered previous value is 0, current value is 1). kb_is_mouse and kb_data are sampled in the same cycle as the edge.
REQ-018 Each push goes to the keyboard FIFO or the mouse FIFO, selected by kb_is_mouse. A level held high produces exactly one push.
REQ-019 Each FIFO holds FIFO_DEPTH entries of {type, data}. Read and write pointers wrap modulo FIFO_DEPTH. The count is a separate register of width clog2(FIFO_DEPTH)+1.
REQ-020 Push into a full FIFO: the push proceeds when that FIFO is popped in the same cycle (count unchanged); otherwise the event is dropped and drop_count increments, saturating at 255.
REQ-021 Scheduler FSM has two states, S_IDLE and S_HOLD.
  - S_IDLE with at least one FIFO non-empty: pop one entry into the output register, set out_valid, go to S_HOLD.
REQ-022 Arbitration is round-robin when both FIFOs are non-empty: grant the FIFO not granted last. The last-grant register resets to mouse, so keyboard wins first.
REQ-023 In S_HOLD, out_valid=1 and out_data/out_is_mouse stay stable until out_valid && out_ready.
REQ-024 On handshake in S_HOLD:
  - If a FIFO is non-empty, pop the next entry in the same cycle and remain in S_HOLD (back-to-back, one event per cycle).
  - Otherwise clear out_valid and go to S_IDLE.
REQ-025 Latency: a push detected in cycle N into empty FIFOs, with the scheduler in S_IDLE, gives out_valid=1 in cycle N+2 (FIFO write in N, pop in N+1, registered output visible in N+2).
REQ-026 A push into a FIFO and a pop from the same FIFO in one cycle are both performed, using pre-update pointers.
REQ-027 LED FSM has three states, L_IDLE, L_EMIT and L_HOLDOFF.
  - led_req_valid in any state loads led_req into a pending register and sets a pending flag; the latest request wins.
REQ-028 L_IDLE with the pending flag set: go to L_EMIT.
REQ-029 L_EMIT, one cycle:
  - led_data_valid=1 and led_data=pending value.
  - Clear the pending flag unless led_req_valid is high this cycle.
  - Load the holdoff counter with LED_HOLDOFF-1 and go to L_HOLDOFF.
REQ-030 L_HOLDOFF: decrement the counter; at 0 return to L_IDLE. Pending requests received meanwhile are emitted after the holdoff ends.
REQ-031 led_data holds the last emitted value between pulses. led_data_valid is never high on two consecutive cycles.

Reset
REQ-032 While rst_n=0 at a clk edge, reset the following:
  - both FIFOs empty (pointers and counts 0), scheduler to S_IDLE, last-grant to mouse;
  - LED FSM to L_IDLE, pending flag 0, holdoff counter 0;
  - kb_data_ready edge register to 1, so a level already high at reset release does not push.
REQ-033 Outputs during and after reset, until new activity:
  - out_valid=0, out_data=0, out_is_mouse=0;
  - led_data_valid=0, led_data=2'b00;
  - drop_count=0.
REQ-034 Reset asserted mid-operation discards queued and in-flight events and any pending LED request, with no further pulses.

Verification
REQ-035 Single event: keyboard push 16'h2A31, out_ready=1 -> out_valid high exactly one cycle, two cycles after the push cycle, with out_data=16'h2A31 and out_is_mouse=0.
REQ-036 Fairness: 3 keyboard pushes (K0..K2) then 3 mouse pushes (M0..M2) while out_ready=0, then out_ready=1 -> output order K0,M0,K1,M1,K2,M2, one event per cycle.
REQ-037 Overflow: 6 keyboard pushes with out_ready=0 and FIFO_DEPTH=4 -> first held in the output register, next 4 queued, sixth dropped with drop_count=1; 300 further drops -> drop_count=255.
REQ-038 Backpressure: out_ready toggled pseudo-randomly over 100 mixed events -> no loss, no duplication, per-type order preserved, out_data stable while out_valid && !out_ready.
REQ-039 LED: led_req 2'b01 then 2'b11 ten cycles later, LED_HOLDOFF=50 -> pulse with 2'b01 two cycles after the first request, pulse with 2'b11 exactly 50 cycles after the first pulse, no third pulse.
REQ-040 Reset mid-stream: rst_n low for one cycle with 3 events queued and out_valid=1 -> next cycle out_valid=0; no stale event appears afterwards; drop_count=0.
